// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and the receiver lock states.
// The draw side imports the same package so both ends agree on the frame geometry.
package vga_pkg;

    localparam int H_VIS = 640;
    localparam int H_FP = 16;
    localparam int H_SYNC = 96;
    localparam int H_BP = 48;
    localparam int V_VIS = 480;
    localparam int V_FP = 10;
    localparam int V_SYNC = 2;
    localparam int V_BP = 33;
    localparam int HTOT = H_SYNC + H_BP + H_VIS + H_FP;
    localparam int VTOT = V_SYNC + V_BP + V_VIS + V_FP;
    localparam int H_ACT = H_SYNC + H_BP;
    localparam int V_ACT = V_SYNC + V_BP;
    localparam int LOCK_FRAMES = 2;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_ALIGN,
        ST_LOCKED
    } rx_state_e;

endpackage

// File: rtl/vga_rx_if.sv
// VGA pin bundle: pixel strobe, active-low syncs and the 3-3-2 colour bus.
interface vga_rx_if;
    logic       pix_ce;
    logic       HS;
    logic       VS;
    logic [2:0] RED;
    logic [2:0] GREEN;
    logic [1:0] BLUE;

    modport master (output pix_ce, HS, VS, RED, GREEN, BLUE);
    modport slave  (input  pix_ce, HS, VS, RED, GREEN, BLUE);
endinterface

// File: rtl/vga_sync_tracker.sv
// Sync edge detector plus position counter; flags edges that land at the wrong count.
// The count reported out is the one belonging to the sample currently being taken.
module vga_sync_tracker #(
    parameter int RISE_AT = 95,
    parameter int FALL_AT = 799,
    parameter bit SAT_CHK = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step_i,
    input  logic       sync_i,
    output logic [9:0] cnt_o,
    output logic       fall_o,
    output logic       err_o
);
    localparam logic [9:0] CNT_MAX = 10'h3FF;

    logic       prev_q;
    logic       rise;
    logic [9:0] cnt_q;
    logic [9:0] cnt_d;

    // Edge positions are judged against the count of the previous sample.
    always_comb begin
        fall_o = step_i & prev_q & ~sync_i;
        rise   = step_i & ~prev_q & sync_i;
        cnt_d  = cnt_q;
        if (fall_o) begin
            cnt_d = '0;
        end else if (step_i && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 10'd1;
        end
        err_o = (rise && cnt_q != 10'(RISE_AT))
              || (fall_o && cnt_q != 10'(FALL_AT))
              || (SAT_CHK && step_i && !fall_o && cnt_q == CNT_MAX - 10'd1);
    end

    assign cnt_o = cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b1;
            cnt_q  <= '0;
        end else if (step_i) begin
            prev_q <= sync_i;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/vga_rx.sv
// VGA receiver: recovers x/y/de from the syncs, tracks timing lock and
// captures one probe pixel's colour per frame.
module vga_rx #(
    parameter int H_VIS = vga_pkg::H_VIS,
    parameter int H_FP = vga_pkg::H_FP,
    parameter int H_SYNC = vga_pkg::H_SYNC,
    parameter int H_BP = vga_pkg::H_BP,
    parameter int V_VIS = vga_pkg::V_VIS,
    parameter int V_FP = vga_pkg::V_FP,
    parameter int V_SYNC = vga_pkg::V_SYNC,
    parameter int V_BP = vga_pkg::V_BP,
    parameter int LOCK_FRAMES = vga_pkg::LOCK_FRAMES
) (
    input  logic           clk,
    input  logic           rst,
    vga_rx_if.slave        vga,
    input  logic [9:0]     probe_x,
    input  logic [9:0]     probe_y,
    output logic [9:0]     x,
    output logic [9:0]     y,
    output logic           de,
    output logic [7:0]     pix,
    output logic           frame_start,
    output logic           locked,
    output logic           h_err,
    output logic           v_err,
    output logic [7:0]     probe_clr,
    output logic           probe_vld
);
    import vga_pkg::rx_state_e;
    import vga_pkg::ST_HUNT;
    import vga_pkg::ST_ALIGN;
    import vga_pkg::ST_LOCKED;

    localparam int HTOT = H_SYNC + H_BP + H_VIS + H_FP;
    localparam int VTOT = V_SYNC + V_BP + V_VIS + V_FP;
    localparam int H_ACT = H_SYNC + H_BP;
    localparam int V_ACT = V_SYNC + V_BP;
    localparam int CW = $clog2(LOCK_FRAMES + 1);

    rx_state_e    state_q, state_d;
    logic [CW-1:0] clean_q, clean_d;
    logic          dirty_q, dirty_d;
    logic [7:0]   rgb;
    logic [9:0]   h_cnt_d, v_cnt_d;
    logic         h_fall, v_fall, h_chk, v_chk;
    logic         vs_s_q, vs_skew;
    logic         h_err_d, v_err_d, any_err;
    logic         hv, vv, de_d, hit;
    logic [9:0]   x_d, y_d;
    logic [9:0]   x_q, y_q, px_q, py_q;
    logic         de_q, fs_q, locked_q, h_err_q, v_err_q, probe_vld_q, cap_q;
    logic [7:0]   pix_q, probe_clr_q, shadow_q;

    assign rgb = {vga.RED, vga.GREEN, vga.BLUE};

    vga_sync_tracker #(.RISE_AT(H_SYNC - 1), .FALL_AT(HTOT - 1), .SAT_CHK(1'b1)) u_h (
        .clk(clk), .rst(rst), .step_i(vga.pix_ce), .sync_i(vga.HS),
        .cnt_o(h_cnt_d), .fall_o(h_fall), .err_o(h_chk)
    );

    vga_sync_tracker #(.RISE_AT(V_SYNC - 1), .FALL_AT(VTOT - 1), .SAT_CHK(1'b0)) u_v (
        .clk(clk), .rst(rst), .step_i(h_fall), .sync_i(vga.VS),
        .cnt_o(v_cnt_d), .fall_o(v_fall), .err_o(v_chk)
    );

    // The line tracker only sees VS at HS falls, so mid-line VS motion is caught here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_s_q <= 1'b1;
        end else if (vga.pix_ce) begin
            vs_s_q <= vga.VS;
        end
    end

    assign vs_skew = vga.pix_ce && (vga.VS != vs_s_q) && (h_cnt_d != '0);
    assign h_err_d = h_chk && (state_q != ST_HUNT);
    assign v_err_d = (v_chk || vs_skew) && (state_q != ST_HUNT);
    assign any_err = h_err_d | v_err_d;

    // An error on the frame_start sample is charged to the frame that just ended.
    always_comb begin
        state_d = state_q;
        clean_d = clean_q;
        dirty_d = dirty_q;
        case (state_q)
            ST_HUNT: begin
                if (v_fall) begin
                    state_d = ST_ALIGN;
                    clean_d = '0;
                    dirty_d = 1'b0;
                end
            end
            ST_ALIGN: begin
                if (v_fall) begin
                    dirty_d = 1'b0;
                    if (dirty_q || any_err) begin
                        clean_d = '0;
                    end else if (clean_q == CW'(LOCK_FRAMES - 1)) begin
                        state_d = ST_LOCKED;
                        clean_d = '0;
                    end else begin
                        clean_d = clean_q + CW'(1);
                    end
                end else if (any_err) begin
                    clean_d = '0;
                    dirty_d = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (any_err) begin
                    state_d = ST_ALIGN;
                    clean_d = '0;
                    dirty_d = ~v_fall;
                end else if (v_fall) begin
                    dirty_d = 1'b0;
                end
            end
            default: state_d = ST_HUNT;
        endcase
    end

    always_comb begin
        hv   = (h_cnt_d >= 10'(H_ACT)) && (h_cnt_d < 10'(H_ACT + H_VIS));
        vv   = (v_cnt_d >= 10'(V_ACT)) && (v_cnt_d < 10'(V_ACT + V_VIS));
        x_d  = hv ? h_cnt_d - 10'(H_ACT) : '0;
        y_d  = vv ? v_cnt_d - 10'(V_ACT) : '0;
        de_d = hv && vv && (state_d == ST_LOCKED);
        hit  = vga.pix_ce && de_d && (x_d == px_q) && (y_d == py_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_HUNT;
            clean_q <= '0;
            dirty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            clean_q <= clean_d;
            dirty_q <= dirty_d;
        end
    end

    // Probe coordinates are frozen at frame_start so a mid-frame change waits a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            px_q     <= '0;
            py_q     <= '0;
            shadow_q <= '0;
            cap_q    <= 1'b0;
        end else if (v_fall) begin
            px_q  <= probe_x;
            py_q  <= probe_y;
            cap_q <= 1'b0;
        end else if (hit) begin
            shadow_q <= rgb;
            cap_q    <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q         <= '0;
            y_q         <= '0;
            de_q        <= 1'b0;
            pix_q       <= '0;
            fs_q        <= 1'b0;
            locked_q    <= 1'b0;
            h_err_q     <= 1'b0;
            v_err_q     <= 1'b0;
            probe_clr_q <= '0;
            probe_vld_q <= 1'b0;
        end else begin
            fs_q        <= v_fall;
            locked_q    <= (state_d == ST_LOCKED);
            h_err_q     <= h_err_d;
            v_err_q     <= v_err_d;
            probe_vld_q <= v_fall & cap_q;
            if (v_fall && cap_q) begin
                probe_clr_q <= shadow_q;
            end
            if (vga.pix_ce) begin
                x_q   <= x_d;
                y_q   <= y_d;
                de_q  <= de_d;
                pix_q <= rgb;
            end
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign de          = de_q;
    assign pix         = pix_q;
    assign frame_start = fs_q;
    assign locked      = locked_q;
    assign h_err       = h_err_q;
    assign v_err       = v_err_q;
    assign probe_clr   = probe_clr_q;
    assign probe_vld   = probe_vld_q;

endmodule

// File: tb/tb_vga_rx.sv
// Bench for vga_rx on a shrunken raster (25x11) so many frames fit in a short run.
// A sample-level reference model predicts every output after each pixel strobe.
module tb_vga_rx;

    localparam int HV = 16, HF = 2, HSW = 4, HB = 3;
    localparam int VV = 6, VF = 1, VSW = 2, VB = 2;
    localparam int LOCKN = 2;
    localparam int HT = HV + HF + HSW + HB;
    localparam int VT = VV + VF + VSW + VB;
    localparam int HA = HSW + HB;
    localparam int VA = VSW + VB;
    localparam int PRX = 8, PRY = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] probeX, probeY;
    logic [9:0] x, y;
    logic       de, frameStart, locked, hErr, vErr, probeVld;
    logic [7:0] pix, probeClr;

    vga_rx_if vif();

    vga_rx #(
        .H_VIS(HV), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB), .LOCK_FRAMES(LOCKN)
    ) dut (
        .clk(clk), .rst(rst), .vga(vif),
        .probe_x(probeX), .probe_y(probeY),
        .x(x), .y(y), .de(de), .pix(pix),
        .frame_start(frameStart), .locked(locked),
        .h_err(hErr), .v_err(vErr),
        .probe_clr(probeClr), .probe_vld(probeVld)
    );

    always #5 clk = ~clk;

    int nChecks = 0, nPass = 0, nFail = 0;
    int cntFs = 0, cntHe = 0, cntVe = 0, cntVld = 0;
    bit cmpEn = 1'b0;
    bit paintProbe = 1'b0;

    // reference model state: plain integers describing where we are in the raster
    int mHprev, mVprev, mVsamp, mHc, mVc, mClean, mPx, mPy;
    bit mSeen, mLock, mDirty, mCap;
    logic [7:0] mShadow;
    logic [9:0] eX, eY;
    logic       eDe, eFs, eLk, eHe, eVe, eVld;
    logic [7:0] ePix, eClr;

    task automatic checkOutput(input string nm, input logic [9:0] act, input logic [9:0] exp);
        nChecks++;
        if (act === exp) begin
            nPass++;
        end else begin
            nFail++;
            if (nFail <= 20)
                $display("[TB] FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mHprev = 1; mVprev = 1; mVsamp = 1; mHc = 0; mVc = 0; mClean = 0;
        mPx = 0; mPy = 0; mSeen = 0; mLock = 0; mDirty = 0; mCap = 0; mShadow = '0;
        eX = '0; eY = '0; eDe = 0; eFs = 0; eLk = 0; eHe = 0; eVe = 0; eVld = 0;
        ePix = '0; eClr = '0;
    endtask

    task automatic modelStep(input logic hs, input logic vs, input logic [7:0] rgb);
        bit he, ve, fs, err, hv, vv;
        int hcOld;
        he = 0; ve = 0; fs = 0; hcOld = mHc;
        if (mHprev == 1 && hs == 1'b0) begin
            if (hcOld != HT - 1) he = 1;
            mHc = 0;
            if (mVprev == 1 && vs == 1'b0) begin
                if (mVc != VT - 1) ve = 1;
                mVc = 0;
                fs = 1;
            end else begin
                if (mVprev == 0 && vs == 1'b1 && mVc != VSW - 1) ve = 1;
                if (mVc < 1023) mVc++;
            end
            mVprev = int'(vs);
        end else begin
            if (mHprev == 0 && hs == 1'b1 && hcOld != HSW - 1) he = 1;
            if (hcOld == 1022) he = 1;
            if (mHc < 1023) mHc++;
        end
        mHprev = int'(hs);
        if (int'(vs) != mVsamp && mHc != 0) ve = 1;
        mVsamp = int'(vs);

        if (!mSeen) begin
            he = 0; ve = 0;
            if (fs) begin mSeen = 1; mClean = 0; mDirty = 0; end
        end else begin
            err = he | ve;
            if (mLock) begin
                if (err) begin mLock = 0; mClean = 0; mDirty = !fs; end
                else if (fs) mDirty = 0;
            end else if (fs) begin
                if (mDirty || err) mClean = 0;
                else mClean++;
                if (mClean >= LOCKN) begin mLock = 1; mClean = 0; end
                mDirty = 0;
            end else if (err) begin
                mClean = 0; mDirty = 1;
            end
        end

        hv = (mHc >= HA) && (mHc < HA + HV);
        vv = (mVc >= VA) && (mVc < VA + VV);
        eX = hv ? 10'(mHc - HA) : 10'd0;
        eY = vv ? 10'(mVc - VA) : 10'd0;
        eDe = hv && vv && mLock;
        eVld = 0;
        if (fs) begin
            eVld = mCap;
            if (mCap) eClr = mShadow;
            mCap = 0; mPx = int'(probeX); mPy = int'(probeY);
        end else if (eDe && int'(eX) == mPx && int'(eY) == mPy) begin
            mShadow = rgb; mCap = 1;
        end
        ePix = rgb; eFs = fs; eLk = mLock; eHe = he; eVe = ve;
    endtask

    // every clock: outputs must match the model, and strobes must be single-cycle
    always @(posedge clk) begin
        #1;
        if (cmpEn) begin
            checkOutput("x", x, eX);
            checkOutput("y", y, eY);
            checkOutput("de", {9'd0, de}, {9'd0, eDe});
            checkOutput("pix", {2'd0, pix}, {2'd0, ePix});
            checkOutput("frame_start", {9'd0, frameStart}, {9'd0, eFs});
            checkOutput("locked", {9'd0, locked}, {9'd0, eLk});
            checkOutput("h_err", {9'd0, hErr}, {9'd0, eHe});
            checkOutput("v_err", {9'd0, vErr}, {9'd0, eVe});
            checkOutput("probe_clr", {2'd0, probeClr}, {2'd0, eClr});
            checkOutput("probe_vld", {9'd0, probeVld}, {9'd0, eVld});
            cntFs += int'(frameStart); cntHe += int'(hErr);
            cntVe += int'(vErr); cntVld += int'(probeVld);
            eFs = 0; eHe = 0; eVe = 0; eVld = 0;
        end
    end

    function automatic logic [7:0] paint(input int ln, input int p);
        if (paintProbe) return (ln == VA + PRY && p == HA + PRX) ? 8'hE3 : 8'h00;
        return 8'((ln * 37 + p * 5) & 255);
    endfunction

    task automatic applyStimulus(input logic hs, input logic vs, input logic [7:0] rgb);
        @(negedge clk);
        vif.HS = hs; vif.VS = vs; {vif.RED, vif.GREEN, vif.BLUE} = rgb; vif.pix_ce = 1'b1;
        modelStep(hs, vs, rgb);
        @(negedge clk);
        vif.pix_ce = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic driveLine(input int ln, input int hlow, input int extra);
        logic vs;
        vs = (ln < VSW) ? 1'b0 : 1'b1;
        for (int p = 0; p < HT + extra; p++) applyStimulus(p >= hlow, vs, paint(ln, p));
    endtask

    task automatic driveLines(input int first, input int last);
        for (int ln = first; ln <= last; ln++) driveLine(ln, HSW, 0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_xy"}, x | y, 10'd0);
        checkOutput({tag, "_pix"}, {2'd0, pix | probeClr}, 10'd0);
        checkOutput({tag, "_flags"}, {4'd0, de, frameStart, locked, hErr, vErr, probeVld}, 10'd0);
    endtask

    int base;

    initial begin
        vif.pix_ce = 1'b0; vif.HS = 1'b1; vif.VS = 1'b1;
        {vif.RED, vif.GREEN, vif.BLUE} = 8'h00;
        probeX = '0; probeY = '0;
        rst = 1'b1;
        modelReset();
        cmpEn = 1'b1;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;

        $display("[TB] nominal frames and lock acquisition");
        driveLines(0, VT - 1);
        driveLines(0, VT - 1);
        checkOutput("locked_before_3rd_fall", {9'd0, locked}, 10'd0);
        driveLines(0, VT - 1);
        checkOutput("locked_after_3rd_fall", {9'd0, locked}, 10'd1);
        checkOutput("frame_start_count", 10'(cntFs), 10'd3);
        checkOutput("err_count_nominal", 10'(cntHe + cntVe), 10'd0);

        $display("[TB] visible window edges");
        driveLines(0, VA - 1);
        for (int p = 0; p < HT; p++) begin
            applyStimulus(p >= HSW, 1'b1, paint(VA, p));
            if (p == HA) begin
                checkOutput("first_vis_x", x, 10'd0);
                checkOutput("first_vis_y", y, 10'd0);
                checkOutput("first_vis_de", {9'd0, de}, 10'd1);
            end
            if (p == HA + HV - 1) begin
                checkOutput("last_vis_x", x, 10'd15);
                checkOutput("last_vis_de", {9'd0, de}, 10'd1);
            end
            if (p == HA + HV) checkOutput("past_vis_de", {9'd0, de}, 10'd0);
        end
        driveLines(VA + 1, VT - 1);

        $display("[TB] short HS pulse");
        base = cntHe;
        for (int ln = 0; ln < VT; ln++) driveLine(ln, (ln == 3) ? HSW - 1 : HSW, 0);
        checkOutput("short_hs_h_err_count", 10'(cntHe - base), 10'd1);
        checkOutput("short_hs_unlocked", {9'd0, locked}, 10'd0);
        driveLines(0, VT - 1);
        driveLines(0, VT - 1);
        checkOutput("short_hs_not_yet_relocked", {9'd0, locked}, 10'd0);
        driveLines(0, VT - 1);
        checkOutput("short_hs_relocked", {9'd0, locked}, 10'd1);

        $display("[TB] short frame");
        base = cntVe;
        driveLines(0, VT - 2);
        driveLines(0, VT - 1);
        checkOutput("short_frame_v_err_count", 10'(cntVe - base), 10'd1);
        checkOutput("short_frame_unlocked", {9'd0, locked}, 10'd0);
        driveLines(0, VT - 1);
        checkOutput("short_frame_not_yet_relocked", {9'd0, locked}, 10'd0);
        driveLines(0, VT - 1);
        checkOutput("short_frame_relocked", {9'd0, locked}, 10'd1);

        $display("[TB] probe capture");
        probeX = 10'(PRX); probeY = 10'(PRY); paintProbe = 1'b1;
        driveLines(0, VT - 1);
        probeX = 10'(HV + 3);
        base = cntVld;
        driveLines(0, VT - 1);
        checkOutput("probe_vld_count", 10'(cntVld - base), 10'd1);
        checkOutput("probe_clr_value", {2'd0, probeClr}, 10'h0E3);
        base = cntVld;
        driveLines(0, VT - 1);
        checkOutput("probe_oob_no_vld", 10'(cntVld - base), 10'd0);
        checkOutput("probe_clr_held", {2'd0, probeClr}, 10'h0E3);

        $display("[TB] missing HS fall saturates the line counter");
        base = cntHe;
        for (int ln = 0; ln < VT; ln++) driveLine(ln, HSW, (ln == 2) ? 1100 : 0);
        checkOutput("stall_h_err_count", 10'(cntHe - base), 10'd2);
        driveLines(0, VT - 1);
        driveLines(0, VT - 1);
        driveLines(0, 5);
        checkOutput("locked_before_reset", {9'd0, locked}, 10'd1);

        $display("[TB] reset mid-frame");
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        checkAllZero("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        driveLines(6, VT - 1);
        driveLines(0, VT - 1);
        driveLines(0, VT - 1);
        checkOutput("reset_not_yet_relocked", {9'd0, locked}, 10'd0);
        driveLines(0, VT - 1);
        checkOutput("reset_relocked", {9'd0, locked}, 10'd1);

        repeat (2) @(negedge clk);
        cmpEn = 1'b0;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
